aes_inv_round_ctrl: RTL

AES_INV_ROUND_CTRL -- requirements
Module: aes_inv_round_ctrl

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/aes_inv_round.sv | 80 ++++++++
 rtl/aes_inv_round_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, round-count constants, controller state enum and GF(2^8)
// helpers used by the inverse round datapath.
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } aes_inv_state_e;

  // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1; constant operands fold away.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map, then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One inverse AES round: InvShiftRows, InvSubBytes, AddRoundKey, then an
// optional InvMixColumns selected by use_mix_i. Byte 0 is [127:120], column-major.
module aes_inv_shift_rows (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  // Row r rotates right by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign data_o[127-8*(4*c+r) -: 8] = data_i[127-8*(4*((c-r+4)%4)+r) -: 8];
    end
  end
endmodule

module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);
  assign data_o = inv_sbox(data_i);
endmodule

module aes_inv_sub_bytes (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  for (genvar b = 0; b < 16; b++) begin : g_byte
    aes_inv_sbox u_sbox (
      .data_i(data_i[8*b +: 8]),
      .data_o(data_o[8*b +: 8])
    );
  end
endmodule

module aes_inv_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = data_i[127-32*c -: 32];
    assign data_o[127-32*c -: 32] = {
      gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
      gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
      gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
      gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
    };
  end
endmodule

module aes_inv_round (
  input  logic [127:0] state_i,
  input  logic [127:0] round_key_i,
  input  logic         use_mix_i,
  output logic [127:0] state_o
);
  logic [127:0] sr, sb, ark, mix;

  aes_inv_shift_rows u_sr (
    .data_i(state_i),
    .data_o(sr)
  );

  aes_inv_sub_bytes u_sb (
    .data_i(sr),
    .data_o(sb)
  );

  assign ark = sb ^ round_key_i;

  aes_inv_mix_columns u_mc (
    .data_i(ark),
    .data_o(mix)
  );

  assign state_o = use_mix_i ? mix : ark;
endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse cipher controller: one round per cycle, round keys
// fetched by index. Optional abort input enabled by AES_INV_CTRL_ABORT_EN.
module aes_inv_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR_128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef AES_INV_CTRL_ABORT_EN
  input  logic         abort,
`endif
  input  logic [127:0] ciphertext,
  output logic [3:0]   key_idx,
  input  logic [127:0] round_key,
  output logic [127:0] plaintext,
  output logic         busy,
  output logic         done
);

  if (!((NR == AES_NR_128) || (NR == AES_NR_192) || (NR == AES_NR_256))) begin : g_bad_nr
    $error("aes_inv_round_ctrl: NR must be 10, 12 or 14");
  end

  aes_inv_state_e fsm_q, fsm_d;
  logic [3:0]     rnd_q, rnd_d;
  aes_block_t     blk_q, blk_d;
  aes_block_t     pt_q, pt_d;
  logic           done_q, done_d;
  aes_block_t     rnd_out;

  aes_inv_round u_round (
    .state_i    (blk_q),
    .round_key_i(round_key),
    .use_mix_i  (fsm_q == ST_ROUND),
    .state_o    (rnd_out)
  );

  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    blk_d   = blk_q;
    pt_d    = pt_q;
    done_d  = 1'b0;
    key_idx = 4'(NR);
    case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          blk_d = ciphertext ^ round_key;
          rnd_d = 4'(NR - 1);
          fsm_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        key_idx = rnd_q;
        blk_d   = rnd_out;
        rnd_d   = rnd_q - 4'd1;
        if (rnd_q == 4'd1) fsm_d = ST_FINAL;
      end
      ST_FINAL: begin
        key_idx = 4'd0;
        pt_d    = rnd_out;
        done_d  = 1'b1;
        fsm_d   = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
`ifdef AES_INV_CTRL_ABORT_EN
    // Abort drops the in-flight block; the last result stays visible.
    if (abort && (fsm_q != ST_IDLE)) begin
      fsm_d  = ST_IDLE;
      rnd_d  = '0;
      blk_d  = blk_q;
      pt_d   = pt_q;
      done_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= ST_IDLE;
      rnd_q  <= '0;
      blk_q  <= '0;
      pt_q   <= '0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      rnd_q  <= rnd_d;
      blk_q  <= blk_d;
      pt_q   <= pt_d;
      done_q <= done_d;
    end
  end

  assign plaintext = pt_q;
  assign done      = done_q;
  assign busy      = (fsm_q == ST_ROUND) || (fsm_q == ST_FINAL);

endmodule
